// File: rtl/bt_uart_rx.sv
// rtl/bt_uart_rx.sv - 8N1 UART receiver presenting each command byte on blue_data for a hold window
module bt_uart_rx #(
    parameter int CLK_FREQ    = 100000000,
    parameter int BAUD        = 9600,
    parameter int HOLD_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] blue_data,
    output logic       byte_valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int DIV = CLK_FREQ / (BAUD * 16);
    localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int HW  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_ACCEPT,
        S_BREAK
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic            rx_m;
    logic            rx_s;
    logic            rx_d;
    logic [DW-1:0]   div_cnt;
    logic            tick;
    logic [3:0]      os_cnt;
    logic            smp7;
    logic            smp8;
    logic            maj;
    logic            mid;
    logic            bit_end;
    logic            fall;
    logic [2:0]      bit_idx;
    logic [7:0]      shreg;
    logic [HW-1:0]   hold_cnt;
    logic            shift_en;
    logic            load;
    logic            ferr;

    // os_cnt counts ticks already seen in the current bit, so a tick with
    // os_cnt==k is tick number k+1: samples on ticks 7/8/9 sit around mid-bit
    // and the tick that wraps 15->0 closes the bit.
    assign tick    = (state != S_IDLE) && (div_cnt == DW'(DIV - 1));
    assign mid     = tick && (os_cnt == 4'd8);
    assign bit_end = tick && (os_cnt == 4'd15);
    assign maj     = (smp7 & smp8) | (smp7 & rx_s) | (smp8 & rx_s);
    assign fall    = rx_d & ~rx_s;
    assign busy    = (state != S_IDLE);

    // Two-flop synchronizer plus one delayed copy for start-edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
            rx_d <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
            rx_d <= rx_s;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and datapath strobes
    always_comb begin
        state_nxt = state;
        shift_en  = 1'b0;
        load      = 1'b0;
        ferr      = 1'b0;
        case (state)
            S_IDLE: begin
                if (fall) begin
                    state_nxt = S_START;
                end
            end
            S_START: begin
                if (mid && maj) begin
                    state_nxt = S_IDLE;
                end else if (bit_end) begin
                    state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                shift_en = mid;
                if (bit_end && (bit_idx == 3'd7)) begin
                    state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                if (mid) begin
                    if (maj) begin
                        load      = 1'b1;
                        state_nxt = S_ACCEPT;
                    end else begin
                        ferr      = 1'b1;
                        state_nxt = S_BREAK;
                    end
                end
            end
            S_ACCEPT: begin
                state_nxt = S_IDLE;
            end
            S_BREAK: begin
                if (rx_s) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Oversample divider and per-bit tick counter, held at zero while idle
    // so the first tick is phase-aligned to the start edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            os_cnt  <= '0;
        end else if (state == S_IDLE) begin
            div_cnt <= '0;
            os_cnt  <= '0;
        end else if (tick) begin
            div_cnt <= '0;
            os_cnt  <= os_cnt + 4'd1;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Mid-bit samples, bit index and LSB-first shift register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            smp7    <= 1'b1;
            smp8    <= 1'b1;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            if (tick && (os_cnt == 4'd6)) begin
                smp7 <= rx_s;
            end
            if (tick && (os_cnt == 4'd7)) begin
                smp8 <= rx_s;
            end
            if (state == S_START) begin
                bit_idx <= '0;
            end else if ((state == S_DATA) && bit_end) begin
                bit_idx <= bit_idx + 3'd1;
            end
            if (shift_en) begin
                shreg <= {maj, shreg[7:1]};
            end
        end
    end

    // Output pulses and hold window; a new byte wins over the expiry clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blue_data  <= 8'h00;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            hold_cnt   <= '0;
        end else begin
            byte_valid <= load;
            frame_err  <= ferr;
            if (load) begin
                blue_data <= shreg;
                hold_cnt  <= HW'(HOLD_CYCLES);
            end else if (hold_cnt != '0) begin
                hold_cnt <= hold_cnt - 1'b1;
                if (hold_cnt == HW'(1)) begin
                    blue_data <= 8'h00;
                end
            end
        end
    end

endmodule

// File: doc/bt_uart_rx.md
Name: bt_uart_rx

Overview:
Serial front end for the Bluetooth command link. Receives 8N1 UART bytes from the HC-05-style module pin and presents each command byte on a parallel bus that feeds the downstream command-decode stage as its `blue_data` input. Each byte is held stable for a programmable window so the downstream debounce counter sees it for many consecutive cycles. After the window the bus returns to 8'h00 ("no command").

Parameters:
CLK_FREQ, 100000000, system clock frequency in Hz
BAUD, 9600, serial bit rate
HOLD_CYCLES, 1000000, clk cycles a received byte stays on blue_data; must be >= 1

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
rx  input  1  raw serial line from Bluetooth module; idles high
blue_data  output  8  last received byte during hold window, else 8'h00
byte_valid  output  1  one-cycle pulse when a byte is accepted
frame_err  output  1  one-cycle pulse when the stop bit is sampled low
busy  output  1  high while not in IDLE

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; blue_data=8'h00; byte_valid=0; frame_err=0; busy=0.
  - All counters cleared; synchronizer flops set to 1.
  - Reset mid-frame abandons the frame; no pulses are produced.
- Synchronizer: rx passes through 2 flops (rx_s). All decisions use rx_s.
- Oversample tick:
  - DIV = CLK_FREQ/(BAUD*16), integer truncation; 651 at the default parameters.
  - A divider counter 0..DIV-1 emits a one-cycle tick on wrap.
  - The counter is cleared on the IDLE->START transition, so ticks are phase-aligned to the start edge.
- Bit sampling:
  - A tick counter 0..15 runs per bit.
  - rx_s is captured at ticks 7, 8 and 9; the bit value is the 2-of-3 majority.
  - A bit is complete at tick 15.
- FSM:
  - IDLE: busy=0. A falling edge on rx_s (previous 1, current 0) -> START.
  - START: at tick 9 (majority known), majority=1 is a false start -> IDLE with no pulses. At the end of tick 15 -> DATA with bit index 0.
  - DATA: 8 bits, LSB first, shifted into a shift register. After bit index 7 completes -> STOP.
  - STOP: evaluated at tick 9 of the stop bit (mid-bit). Majority=1 -> ACCEPT. Majority=0 -> frame_err=1 for one cycle, byte discarded, -> BREAK.
  - ACCEPT (one cycle): blue_data<=shift register; byte_valid=1; hold counter<=HOLD_CYCLES; -> IDLE. IDLE is re-entered mid-stop-bit so a back-to-back start edge is caught.
  - BREAK: wait until rx_s=1, then -> IDLE. A line held low never produces repeated errors.
- Hold window:
  - While the hold counter is >0 it decrements each cycle.
  - On the cycle the counter transitions 1->0, blue_data<=8'h00.
  - A new ACCEPT during the window overwrites blue_data and reloads the counter; there is no gap cycle of 8'h00.
  - A received 8'h00 is accepted normally: byte_valid pulses and blue_data=0.
  - A frame error does not disturb blue_data or the hold counter.
- Latency: byte_valid rises 2 (sync) + 9.5 bit times + 1 cycle after the rx falling edge, to within 1 tick.
- Simultaneous events: ACCEPT takes priority over the hold-expiry clear in the same cycle; the new byte is loaded.
- Baud tolerance: must receive correctly with a transmitter mismatch of ±3%.

Test Plan:
Bench parameters: CLK_FREQ=1600000, BAUD=10000 (DIV=10, 160 cycles/bit), HOLD_CYCLES=500.
- Single byte 8'h04 (start, 00100000 LSB-first, stop) -> one byte_valid pulse. blue_data=8'h04 from that cycle for exactly 500 cycles, then 8'h00. frame_err stays 0.
- Back-to-back 8'h01 then 8'h40, no idle gap -> two byte_valid pulses ~1600 cycles apart. blue_data goes 01 -> 40 with no intermediate 00. Hold reloads; the 00 clear occurs 500 cycles after the second pulse.
- Stop bit forced low on byte 8'h02, then rx held low 3000 cycles -> single frame_err pulse and no byte_valid. blue_data unchanged. busy stays 1 until rx returns high, then the next valid byte 8'h08 is received correctly.
- 40-cycle low glitch on an idle line -> false start. No pulses; busy returns 0 within 100 cycles of the glitch start.
- rst_n asserted at bit 4 of byte 8'hFF, released after 20 cycles -> outputs 0 immediately (asynchronous). The aborted byte is never presented; the following clean byte 8'h04 is received.
- Byte 8'h08 sent at 3% fast and at 3% slow bit period -> received as 8'h08 both times with no frame_err.
